digit_scan_controller: RTL
==========================

# digit_scan_controller

Time-multiplexes up to `DIGITS` 4-bit digit values onto one shared hex-to-segment decoder and a set of common digit-select lines. Each digit is scanned in turn with a programmable dwell time, and a blanking guard interval separates digits to prevent ghosting. Disabled digits are skipped, and leading zeros can be suppressed. The block sits between the digit counters and the single display decoder.

## Interface
Parameters:
- `DIGITS`, 4, number of scanned digits (2..8)
- `DWELL`, 50000, clock cycles a digit is shown (≥1)
- `GUARD`, 500, clock cycles all selects are off between digits (≥1)

Ports:
- `clock` in 1: single clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high
- `values` in 4*DIGITS: digit i occupies bits [4i+3:4i]; digit DIGITS-1 is most significant
- `digit_enable` in DIGITS: per-digit scan mask
- `lz_suppress` in 1: 1 blanks leading zeros
- `select` out DIGITS: one-hot digit select, active-high
- `hex` out 4: value to the shared decoder
- `blank` out 1: 1 means the decoder output must be dark
- `frame_start` out 1: one-cycle pulse at the start of each scan frame

## Operation
- FSM states:
  - GUARD: `select`=0, `blank`=1, `hex` holds its last value.
  - SHOW: exactly one `select` bit is high.
- GUARD→SHOW happens after GUARD cycles, but only if `digit_enable` != 0. If the mask is zero, the FSM stays in GUARD with its counter held at terminal.
- Next-index search at the GUARD→SHOW transition:
  - Start at (idx+1) mod DIGITS and take the first enabled digit, scanning cyclically.
  - A single enabled digit selects itself.
- SHOW→GUARD happens after DWELL cycles, or on the cycle after `digit_enable[idx]` is sampled 0 (dwell cut short).
- Frame start is declared on a GUARD→SHOW transition where any of these holds:
  - new idx ≤ old idx (wrap),
  - it is the first transition after reset,
  - it is the first transition after an all-disabled period.
- On frame start:
  - `values` and `lz_suppress` are captured into a snapshot register.
  - `frame_start` pulses for one cycle, aligned with the first SHOW cycle.
- All displayed data comes from the snapshot; mid-frame changes on `values` do not tear the display.
- Leading-zero rule, evaluated on the snapshot:
  - Digit i > 0 is suppressed if snapshot lz=1 and digits i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
- Outputs in SHOW:
  - `hex` = snapshot digit idx.
  - `blank` = 1 if that digit is suppressed, else 0.
  - `select` stays asserted even when the digit is suppressed.
- Counter width is clog2(max(DWELL,GUARD)+1). Counters reset to 0 on every state change.

## Timing
- Reset values:
  - `select`=0, `hex`=0, `blank`=1, `frame_start`=0
  - state=GUARD, counter=0, idx=DIGITS-1 (so the first pick is the lowest enabled digit), snapshot=0
- All outputs are registered and change only on clock edges.
- Per-digit period is GUARD+DWELL cycles. A full frame with k enabled digits takes k·(GUARD+DWELL) cycles.
- After `reset` deasserts, the first SHOW cycle is cycle GUARD, counting the first non-reset edge as cycle 0.
- `digit_enable` is sampled in two places only:
  - at the GUARD→SHOW decision,
  - each SHOW cycle, for the cut.
- Reset asserted mid-operation overrides everything on that edge and returns the block to its reset values.
- No two selects are ever high on the same cycle. `select` is never high during GUARD.

## Structure
- Package `digit_scan_pkg` holds:
  - state encoding constants (GUARD, SHOW),
  - the clog2-based counter-width function.
- Sub-module `digit_scan_next` is a combinational cyclic priority finder. Inputs: mask and current idx. Outputs: next idx, a wrap flag, and a none-enabled flag.
- The top level holds the FSM, counter, snapshot, lz-suppress logic and output registers.

## Test plan
With DIGITS=4, DWELL=4, GUARD=2:
- **Basic scan.** Full mask, `values`=0x4321, lz=0.
  - `select` sequence: 0001×4, 0000×2, 0010×4, 0000×2, 0100, 1000, then 0001 again.
  - `hex` reads 1,2,3,4 in those windows.
  - `frame_start` pulses at cycle 2 and cycle 26.
- **Skip disabled.** mask=1010.
  - Only selects 0010 and 1000 alternate; frame period is 12 cycles.
  - mask=0000 → `select` held at 0 and `blank`=1 indefinitely; restoring the mask → `frame_start` on the first SHOW.
- **Leading zeros.** `values`=0x0050, lz=1.
  - Digits 3 and 2 show `blank`=1 with `select` asserted.
  - Digits 1 and 0 show `blank`=0 with `hex`=5 and `hex`=0.
  - `values`=0x0000 → only digit 0 is unblanked.
- **Snapshot.** Change `values` 0x1111→0x2222 during the SHOW of digit 1.
  - Digits 2 and 3 still show 1.
  - The next frame shows 2 on all digits.
- **Dwell cut.** Clear `digit_enable[1]` on the 2nd SHOW cycle of digit 1.
  - The next cycle enters GUARD.
  - Digit 2 is shown 2 cycles later.
- **Reset mid-SHOW.** Pulse `reset` for one cycle.
  - The following edge shows `select`=0, `blank`=1, `hex`=0.
  - First SHOW is digit 0 after 2 guard cycles, with `frame_start`=1.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared types and sizing helpers for the digit scan controller.
package digit_scan_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Width needed to count up to the longer of the two phase lengths.
  function automatic int cnt_width(input int dwell, input int guard);
    int m;
    m = (dwell > guard) ? dwell : guard;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/digit_scan_next.sv
// Cyclic priority finder: first enabled digit after idx, wrapping around.
module digit_scan_next
  import digit_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int IW     = $clog2(DIGITS)
) (
  input  logic [DIGITS-1:0] mask,
  input  logic [IW-1:0]     idx,
  output logic [IW-1:0]     next_idx,
  output logic              wrap,
  output logic              none
);

  logic [IW-1:0] j;

  // Walk candidates from farthest to nearest so the nearest enabled one wins;
  // k == DIGITS lands back on idx, so a lone enabled digit picks itself.
  always_comb begin
    next_idx = idx;
    none     = 1'b1;
    j        = '0;
    for (int k = DIGITS; k >= 1; k--) begin
      j = IW'((int'(idx) + k) % DIGITS);
      if (mask[j]) begin
        next_idx = j;
        none     = 1'b0;
      end
    end
    wrap = !none && (next_idx <= idx);
  end

endmodule

// File: rtl/digit_scan_controller.sv
// Multiplexes DIGITS nibbles onto one decoder with dwell/guard timing,
// per-frame snapshot of the data and leading-zero blanking.
module digit_scan_controller
  import digit_scan_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int GUARD  = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [DIGITS-1:0]     digit_enable,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     select,
  output logic [3:0]            hex,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = cnt_width(DWELL, GUARD);
  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]     GUARD_LAST = CW'(GUARD - 1);
  localparam logic [DIGITS-1:0] SEL_LSB    = DIGITS'(1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       next_idx;
  logic                wrap;
  logic                none;
  logic                first;      // next SHOW entry opens a frame regardless of wrap
  logic                fs;
  logic [4*DIGITS-1:0] snap_vals;
  logic                snap_lz;
  logic [4*DIGITS-1:0] show_vals;
  logic                show_lz;
  logic [3:0]          show_hex;
  logic                show_blank;
  logic                upper_zero;

  digit_scan_next #(.DIGITS(DIGITS), .IW(IW)) u_next (
    .mask     (digit_enable),
    .idx      (idx),
    .next_idx (next_idx),
    .wrap     (wrap),
    .none     (none)
  );

  // Data for the digit about to be shown; a frame start takes live inputs
  // since the snapshot is being loaded on that same edge.
  always_comb begin
    fs         = wrap | first;
    show_vals  = fs ? values : snap_vals;
    show_lz    = fs ? lz_suppress : snap_lz;
    show_hex   = show_vals[4*int'(next_idx) +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(next_idx) && show_vals[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    show_blank = show_lz && (next_idx != '0) && upper_zero;
  end

  // Scan FSM with phase counter, snapshot and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_GUARD;
      cnt         <= '0;
      idx         <= IW'(DIGITS - 1);
      first       <= 1'b1;
      snap_vals   <= '0;
      snap_lz     <= 1'b0;
      select      <= '0;
      hex         <= 4'd0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_GUARD: begin
          if (cnt == GUARD_LAST) begin
            if (none) begin
              first <= 1'b1;       // hold at terminal until something is enabled
            end else begin
              state       <= ST_SHOW;
              cnt         <= '0;
              idx         <= next_idx;
              first       <= 1'b0;
              select      <= SEL_LSB << next_idx;
              hex         <= show_hex;
              blank       <= show_blank;
              frame_start <= fs;
              if (fs) begin
                snap_vals <= values;
                snap_lz   <= lz_suppress;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST || !digit_enable[idx]) begin
            state  <= ST_GUARD;
            cnt    <= '0;
            select <= '0;
            blank  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_GUARD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
